// File: rtl/fb_mem_arbiter_pkg.sv
// Shared framebuffer geometry, bus widths and clear-engine state encodings.
package fb_mem_arbiter_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   localparam int FB_ADDR_W     = 19;
   localparam int FB_DATA_W     = 16;
   localparam int FB_WORDS_DEF  = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int FB_FIFO_DEPTH = 4;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_BUSY = 1'b1
   } clr_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering renderer writes as {addr, data} entries.
module fb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok, pop_ok;

   // A push while full is refused even if a pop frees a slot this cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: VGA reads first, then the clear engine, then the
// buffered renderer writes. One RAM access per cycle.
module fb_mem_arbiter
   import fb_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FB_WORDS   = FB_WORDS_DEF,
   parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_rd,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_oob,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
   localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W+1)'(FB_WORDS);

   clr_state_t          state, state_nxt;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
   logic [DATA_W-1:0]   clr_color_q, clr_color_nxt;
   logic                clr_done_nxt;

   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ADDR_W+DATA_W-1:0] fifo_dout;
   logic                in_range, wr_fire;

   // The RAM returns data one cycle after the grant; pass it straight through.
   assign vga_data = mem_rdata;

   assign clr_busy  = (state == CLR_BUSY);
   assign wr_ready  = !fifo_full;
   assign wr_fire   = wr_valid && wr_ready;
   assign in_range  = ({1'b0, wr_addr} < FB_LIMIT);
   assign fifo_push = wr_fire && in_range;

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({wr_addr, wr_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= CLR_IDLE;
         clr_cnt     <= '0;
         clr_color_q <= '0;
         clr_done    <= 1'b0;
         wr_oob      <= 1'b0;
      end else begin
         state       <= state_nxt;
         clr_cnt     <= clr_cnt_nxt;
         clr_color_q <= clr_color_nxt;
         clr_done    <= clr_done_nxt;
         if (wr_fire && !in_range) wr_oob <= 1'b1;
      end
   end

   // The clear only advances in cycles the scan-out leaves free.
   always_comb begin
      state_nxt     = state;
      clr_cnt_nxt   = clr_cnt;
      clr_color_nxt = clr_color_q;
      clr_done_nxt  = 1'b0;
      case (state)
         CLR_IDLE: begin
            if (clr_start) begin
               clr_color_nxt = clr_color;
               clr_cnt_nxt   = '0;
               state_nxt     = CLR_BUSY;
            end
         end
         CLR_BUSY: begin
            if (!vga_rd) begin
               if (clr_cnt == LAST_ADDR) begin
                  state_nxt    = CLR_IDLE;
                  clr_done_nxt = 1'b1;
               end else begin
                  clr_cnt_nxt = clr_cnt + ADDR_W'(1);
               end
            end
         end
         default: state_nxt = CLR_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (vga_rd) begin
         mem_en   = 1'b1;
         mem_addr = vga_addr;
      end else if (clr_busy) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = clr_cnt;
         mem_wdata = clr_color_q;
      end else if (!fifo_empty) begin
         fifo_pop  = 1'b1;
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
         mem_wdata = fifo_dout[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench: stimulus queues expected RAM ops, a negedge monitor checks them.
module tb_fb_mem_arbiter;

   localparam int AW = 19;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sel, vga_rd, wr_valid, clr_start;
   logic [AW-1:0] vga_addr, wr_addr;
   logic [DW-1:0] wr_data, clr_color;

   logic [DW-1:0] b_vga_data, b_mem_wdata, b_mem_rdata;
   logic [DW-1:0] s_vga_data, s_mem_wdata, s_mem_rdata;
   logic [AW-1:0] b_mem_addr, s_mem_addr;
   logic b_wr_ready, b_clr_busy, b_clr_done, b_wr_oob, b_mem_en, b_mem_we;
   logic s_wr_ready, s_clr_busy, s_clr_done, s_wr_oob, s_mem_en, s_mem_we;

   // Full-size instance, and a tiny one so a whole clear fits in a few cycles.
   fb_mem_arbiter u_big (
      .clk(clk), .rst(rst),
      .vga_rd(vga_rd & ~sel), .vga_addr(vga_addr), .vga_data(b_vga_data),
      .wr_valid(wr_valid & ~sel), .wr_ready(b_wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_start(clr_start & ~sel), .clr_color(clr_color),
      .clr_busy(b_clr_busy), .clr_done(b_clr_done), .wr_oob(b_wr_oob),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   fb_mem_arbiter #(.FB_WORDS(8)) u_small (
      .clk(clk), .rst(rst),
      .vga_rd(vga_rd & sel), .vga_addr(vga_addr), .vga_data(s_vga_data),
      .wr_valid(wr_valid & sel), .wr_ready(s_wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_start(clr_start & sel), .clr_color(clr_color),
      .clr_busy(s_clr_busy), .clr_done(s_clr_done), .wr_oob(s_wr_oob),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
   );

   // RAM models; the big one holds 0xBEEF at 0x123 after reset.
   logic [DW-1:0] b_mem [0:1023];
   logic [DW-1:0] s_mem [0:7];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) b_mem[i] <= (i == 'h123) ? 16'hBEEF : 16'h0;
         b_mem_rdata <= '0;
      end else if (b_mem_en) begin
         if (b_mem_we) b_mem[b_mem_addr[9:0]] <= b_mem_wdata;
         else          b_mem_rdata <= b_mem[b_mem_addr[9:0]];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) s_mem[i] <= '0;
         s_mem_rdata <= '0;
      end else if (s_mem_en) begin
         if (s_mem_we) s_mem[s_mem_addr[2:0]] <= s_mem_wdata;
         else          s_mem_rdata <= s_mem[s_mem_addr[2:0]];
      end
   end

   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_vga_data;
   assign m_en       = sel ? s_mem_en    : b_mem_en;
   assign m_we       = sel ? s_mem_we    : b_mem_we;
   assign m_addr     = sel ? s_mem_addr  : b_mem_addr;
   assign m_wdata    = sel ? s_mem_wdata : b_mem_wdata;
   assign m_vga_data = sel ? s_vga_data  : b_vga_data;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   op_t q[$];
   op_t mon_o;
   int  total = 0;
   int  bad = 0;
   logic          mon_on = 1'b0;
   logic          rd_pend = 1'b0;
   logic [DW-1:0] rd_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic exp_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_t o;
      o.we = we; o.addr = a; o.data = d;
      q.push_back(o);
   endtask

   always @(negedge clk) begin
      if (!mon_on) begin
         rd_pend = 1'b0;
      end else begin
         if (rd_pend) begin
            chk("rd_data", 32'(m_vga_data), 32'(rd_exp));
            rd_pend = 1'b0;
         end
         if (m_en) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_op: got we=%b addr=%h want no access", m_we, m_addr);
            end else begin
               mon_o = q.pop_front();
               chk("op_we", 32'(m_we), 32'(mon_o.we));
               chk("op_addr", 32'(m_addr), 32'(mon_o.addr));
               if (mon_o.we) chk("op_wdata", 32'(m_wdata), 32'(mon_o.data));
               else begin rd_pend = 1'b1; rd_exp = mon_o.data; end
            end
         end else begin
            chk("idle_we", 32'(m_we), 32'h0);
            chk("idle_addr", 32'(m_addr), 32'h0);
            chk("idle_wdata", 32'(m_wdata), 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      vga_rd = 0; vga_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
      clr_start = 0; clr_color = '0;
   endtask

   task automatic do_reset(input int n);
      mon_on = 0; q.delete(); rst = 1; idle();
      repeat (n) step();
      rst = 0; mon_on = 1;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 20) begin step(); n++; end
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL %s: got %0d pending ops want 0", nm, q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      sel = 0; rst = 1; idle();
      @(posedge clk); #1;

      // Reset with random inputs on the big instance.
      for (int i = 0; i < 2; i++) begin
         vga_rd = 1'($urandom); vga_addr = AW'($urandom); wr_valid = 1'($urandom);
         wr_addr = AW'($urandom); wr_data = DW'($urandom);
         clr_start = 1'($urandom); clr_color = DW'($urandom);
         step();
      end
      idle();
      @(negedge clk);
      chk("rst_wr_ready", 32'(b_wr_ready), 1);
      chk("rst_clr_busy", 32'(b_clr_busy), 0);
      chk("rst_clr_done", 32'(b_clr_done), 0);
      chk("rst_wr_oob", 32'(b_wr_oob), 0);
      chk("rst_mem_en", 32'(b_mem_en), 0);
      rst = 0;
      step();
      mon_on = 1;

      // Read priority over a pending FIFO write.
      vga_rd = 1; vga_addr = 19'h00005;
      wr_valid = 1; wr_addr = 19'h00010; wr_data = 16'h0ABC;
      exp_op(0, 19'h00005, 16'h0000);
      @(negedge clk); chk("prio_wr_ready", 32'(b_wr_ready), 1);
      step();
      wr_valid = 0; vga_addr = 19'h00123;
      exp_op(0, 19'h00123, 16'hBEEF);
      @(negedge clk);
      chk("prio_rd_addr", 32'(b_mem_addr), 32'h123);
      chk("prio_rd_we", 32'(b_mem_we), 0);
      step();
      vga_rd = 0;
      exp_op(1, 19'h00010, 16'h0ABC);
      @(negedge clk);
      chk("prio_wr_same_cycle", 32'(b_mem_we), 1);
      step();
      drain("prio_drain");

      // FIFO fill while scan-out holds the RAM.
      vga_rd = 1; vga_addr = '0;
      for (int i = 1; i <= 4; i++) begin
         wr_valid = 1; wr_addr = AW'(i); wr_data = DW'(16'h1000 + i);
         exp_op(0, '0, 16'h0);
         @(negedge clk); chk("full_accept_ready", 32'(b_wr_ready), 1);
         step();
      end
      wr_addr = 19'd5; wr_data = 16'h1005;
      for (int i = 0; i < 2; i++) begin
         exp_op(0, '0, 16'h0);
         @(negedge clk); chk("full_hold_ready", 32'(b_wr_ready), 0);
         step();
      end
      vga_rd = 0;
      for (int i = 1; i <= 5; i++) exp_op(1, AW'(i), DW'(16'h1000 + i));
      @(negedge clk); chk("full_pop_no_push", 32'(b_wr_ready), 0);
      step();
      @(negedge clk); chk("full_reopen_ready", 32'(b_wr_ready), 1);
      step();
      wr_valid = 0;
      drain("full_drain");
      step();

      // Clear on the 8-word instance with scan-out toggling.
      sel = 1;
      do_reset(1);
      clr_start = 1; clr_color = 16'h0F00;
      @(negedge clk); chk("clr_busy_pre", 32'(s_clr_busy), 0);
      step();
      for (int k = 1; k <= 16; k++) begin
         vga_rd = (k % 2 == 1); vga_addr = 19'd6;
         clr_start = (k == 3); clr_color = (k == 3) ? 16'h00F0 : 16'h0F00;
         wr_valid = (k == 5); wr_addr = 19'd3; wr_data = 16'h0123;
         if (k % 2 == 1) exp_op(0, 19'd6, (k == 15) ? 16'h0F00 : 16'h0000);
         else            exp_op(1, AW'(k / 2 - 1), 16'h0F00);
         @(negedge clk);
         chk("clr_busy", 32'(s_clr_busy), 1);
         chk("clr_done_early", 32'(s_clr_done), 0);
         if (k == 5) chk("clr_fifo_ready", 32'(s_wr_ready), 1);
         step();
      end
      idle();
      exp_op(1, 19'd3, 16'h0123);
      @(negedge clk);
      chk("clr_busy_end", 32'(s_clr_busy), 0);
      chk("clr_done_pulse", 32'(s_clr_done), 1);
      step();
      @(negedge clk); chk("clr_done_once", 32'(s_clr_done), 0);
      step();
      drain("clr_drain");
      chk("ram3_order", 32'(s_mem[3]), 32'h0123);
      chk("ram0_clear", 32'(s_mem[0]), 32'h0F00);
      chk("ram7_clear", 32'(s_mem[7]), 32'h0F00);

      // Out-of-range write on the full-size instance.
      sel = 0;
      do_reset(1);
      wr_valid = 1; wr_addr = 19'd307200; wr_data = 16'h5555;
      @(negedge clk);
      chk("oob_pre", 32'(b_wr_oob), 0);
      chk("oob_ready", 32'(b_wr_ready), 1);
      step();
      wr_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("oob_sticky", 32'(b_wr_oob), 1);
         chk("oob_no_we", 32'(b_mem_we), 0);
         step();
      end
      do_reset(1);
      @(negedge clk); chk("oob_cleared", 32'(b_wr_oob), 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Owns the single-port framebuffer RAM (19-bit word address, 16-bit words, 1-cycle synchronous read).
- Shares the RAM between three requesters:
  - the VGA scan-out read port, highest priority;
  - a renderer write port with valid/ready handshake, buffered in a small write FIFO;
  - an internal clear/fill engine that paints the whole framebuffer one colour.
- Sits between the game renderer, the VGA timing/pixel-fetch block and the framebuffer BRAM.

Parameters:
- ADDR_W, 19, framebuffer word address width
- DATA_W, 16, framebuffer word width (rgb in [11:0])
- FB_WORDS, 307200, valid words (SCREEN_WIDTH*SCREEN_HEIGHT); addresses >= FB_WORDS are out of range
- FIFO_DEPTH, 4, renderer write FIFO entries (power of two)

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vga_rd  in  1  scan-out read request this cycle
- vga_addr  in  ADDR_W  scan-out read address
- vga_data  out  DATA_W  read data; equals mem_rdata
- wr_valid  in  1  renderer write request
- wr_ready  out  1  FIFO can accept; transfer when wr_valid && wr_ready
- wr_addr  in  ADDR_W  renderer write address
- wr_data  in  DATA_W  renderer write data
- clr_start  in  1  start clear; sampled only when idle
- clr_color  in  DATA_W  fill value, latched on accepted clr_start
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse on clear completion
- wr_oob  out  1  sticky: an out-of-range write was dropped
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read

Behaviour:
- Reset values (rst=1 at a clk edge):
  - FIFO emptied; engine to IDLE.
  - wr_ready=1, clr_busy=0, clr_done=0, wr_oob=0.
  - Clear counter and latched colour cleared to 0.
  - Reset mid-clear aborts the clear with no clr_done.
- Memory outputs are combinational from the current grant. Per-cycle grant, priority order:
  1. vga_rd=1: mem_en=1, mem_we=0, mem_addr=vga_addr. Nothing else issues that cycle.
  2. Else if clr_busy: write clr_color to clear-counter address; counter increments.
  3. Else if FIFO non-empty: pop head, mem_en=1, mem_we=1, head address and data.
  4. Else mem_en=0, mem_we=0; mem_addr and mem_wdata are 0.
- Read latency:
  - Exactly 1 cycle: data for a read granted in cycle N appears on vga_data in cycle N+1.
  - Reads are never stalled or reordered.
- Write FIFO:
  - wr_ready = !full, from the registered occupancy count.
  - A push while full is not accepted, even if a pop happens that cycle.
  - Push and pop in the same cycle when non-full/non-empty: occupancy unchanged.
  - Draining stops while clr_busy. Writes accepted during a clear therefore land after the clear, in order.
- Out-of-range writes (wr_addr >= FB_WORDS):
  - Handshake completes normally but nothing is pushed.
  - wr_oob is set and held until rst.
- Clear FSM has two states:
  - IDLE: clr_start=1 latches clr_color, counter=0, goes to CLEAR. clr_busy=1 from the next cycle.
  - CLEAR: one write per cycle not taken by vga_rd. When the write to FB_WORDS-1 issues, the FSM returns to IDLE, and the next cycle has clr_busy=0 and clr_done=1 for one cycle.
  - clr_start while CLEAR is ignored.
  - The counter is ADDR_W bits and never wraps past FB_WORDS-1.
- Throughput: one RAM access per cycle. Writes only progress in cycles where vga_rd=0, i.e. during blanking.

Decomposition:
- FB_WORDS, ADDR_W, DATA_W and clear-state encodings go in the shared game parameter include, next to SCREEN_WIDTH/SCREEN_HEIGHT.
- One sub-module: fb_wr_fifo. Synchronous FIFO, FIFO_DEPTH x (ADDR_W+DATA_W), push/pop/full/empty, synchronous active-high reset.

Test Plan:
- Reset: drive rst 2 cycles with random inputs. Expect wr_ready=1, clr_busy=0, clr_done=0, wr_oob=0, and mem_en=0 once inputs are idle.
- Read priority: FIFO holds (0x00010, 0x0ABC); vga_rd=1, vga_addr=0x00123. Expect mem_addr=0x00123, mem_we=0, and vga_data=mem_rdata next cycle. When vga_rd drops, the write issues that same cycle.
- FIFO full: hold vga_rd=1; push writes to addrs 1..5. Expect wr_ready=0 after 4th accept and 5th held. Release vga_rd: addrs 1..4 then 5 are written in order, one per cycle.
- Clear (FB_WORDS=8), clr_color=0x0F00, vga_rd toggling 1/0: writes to addrs 0..7 only on vga_rd=0 cycles; clr_busy 1 until the last write; clr_done pulses once. A second clr_start mid-clear is ignored.
- Ordering: push write (0x00003, 0x0123) during the clear. It reaches RAM only after the clear's write to addr 7; final RAM[3]=0x0123.
- Out of range: write addr 307200 with default FB_WORDS. Handshake completes, no mem_we, wr_oob=1 and stays 1 until rst.
